// File: rtl/sample_iterator_pkg.sv
// Shared raster definitions: walk FSM states, multisample codes and the
// sub-sample stride derived from a code.
package sample_iterator_pkg;

    typedef enum logic {
        WAIT_STATE = 1'b0,
        TEST_STATE = 1'b1
    } state_e;

    localparam logic [3:0] SS_1X  = 4'b1000;
    localparam logic [3:0] SS_4X  = 4'b0100;
    localparam logic [3:0] SS_16X = 4'b0010;
    localparam logic [3:0] SS_64X = 4'b0001;

    // Non-one-hot codes fall back to the 1x pixel stride.
    function automatic logic [31:0] stride_f(input logic [3:0] code, input int radix);
        logic [31:0] one;
        one = 32'd1;
        case (code)
            SS_4X:   return one << (radix - 1);
            SS_16X:  return one << (radix - 2);
            SS_64X:  return one << (radix - 3);
            default: return one << radix;
        endcase
    endfunction

endpackage

// File: rtl/sample_stepper.sv
// Combinational raster step: next (x,y) and end-of-box flag. Steps are taken
// one bit wider than SIGFIG so a box touching +max cannot wrap the compare.
module sample_stepper #(
    parameter int SIGFIG = 24
) (
    input  logic signed [SIGFIG-1:0] x_i,
    input  logic signed [SIGFIG-1:0] y_i,
    input  logic signed [SIGFIG-1:0] ll_x_i,
    input  logic signed [SIGFIG-1:0] ur_x_i,
    input  logic signed [SIGFIG-1:0] ur_y_i,
    input  logic        [SIGFIG-1:0] stride_i,
    output logic signed [SIGFIG-1:0] next_x_o,
    output logic signed [SIGFIG-1:0] next_y_o,
    output logic                     end_box_o
);

    logic signed [SIGFIG:0] x_step;
    logic signed [SIGFIG:0] y_step;
    logic signed [SIGFIG:0] ur_x_ext;
    logic signed [SIGFIG:0] ur_y_ext;
    logic signed [SIGFIG:0] stride_ext;
    logic                   end_row;

    assign stride_ext = {1'b0, stride_i};
    assign ur_x_ext   = {ur_x_i[SIGFIG-1], ur_x_i};
    assign ur_y_ext   = {ur_y_i[SIGFIG-1], ur_y_i};
    assign x_step     = {x_i[SIGFIG-1], x_i} + stride_ext;
    assign y_step     = {y_i[SIGFIG-1], y_i} + stride_ext;

    assign end_row   = x_step > ur_x_ext;
    assign end_box_o = end_row && (y_step > ur_y_ext);
    assign next_x_o  = end_row ? ll_x_i : x_step[SIGFIG-1:0];
    assign next_y_o  = end_row ? y_step[SIGFIG-1:0] : y_i;

endmodule

// File: rtl/sample_iterator.sv
// Walks every sub-sample of an accepted bounding box in raster order, one per
// cycle, with the latched triangle and color held alongside.
module sample_iterator
    import sample_iterator_pkg::*;
#(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S,
    input  logic        [COLORS-1:0][SIGFIG-1:0]          color_R13U,
    input  logic signed [1:0][1:0][SIGFIG-1:0]            box_R13S,
    input  logic                                         validTri_R13H,
    input  logic [3:0]                                   subSample_RnnnnU,
    output logic                                         halt_RnnnnH,
    output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
    output logic        [COLORS-1:0][SIGFIG-1:0]          color_R14U,
    output logic signed [1:0][SIGFIG-1:0]                 sample_R14S,
    output logic                                         validSamp_R14H
);

    state_e state_q, state_d;

    logic signed [SIGFIG-1:0] x_q, y_q;
    logic signed [SIGFIG-1:0] ll_x_q, ur_x_q, ur_y_q;
    logic        [SIGFIG-1:0] stride_q, stride_d;
    logic signed [SIGFIG-1:0] next_x, next_y;
    logic                     end_box;
    logic                     box_ok;
    logic                     accept;
    logic                     valid_q;

    logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q;
    logic        [COLORS-1:0][SIGFIG-1:0]          color_q;

    assign box_ok = ($signed(box_R13S[1][0]) >= $signed(box_R13S[0][0])) &&
                    ($signed(box_R13S[1][1]) >= $signed(box_R13S[0][1]));
    assign stride_d = SIGFIG'(stride_f(subSample_RnnnnU, RADIX));

    sample_stepper #(.SIGFIG(SIGFIG)) u_stepper (
        .x_i       (x_q),
        .y_i       (y_q),
        .ll_x_i    (ll_x_q),
        .ur_x_i    (ur_x_q),
        .ur_y_i    (ur_y_q),
        .stride_i  (stride_q),
        .next_x_o  (next_x),
        .next_y_o  (next_y),
        .end_box_o (end_box)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= WAIT_STATE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_STATE: if (accept)  state_d = TEST_STATE;
            TEST_STATE: if (end_box) state_d = WAIT_STATE;
            default:                 state_d = WAIT_STATE;
        endcase
    end

    always_comb begin
        halt_RnnnnH = (state_q == WAIT_STATE);
        accept      = halt_RnnnnH && validTri_R13H && box_ok;
    end

    // Box and stride are frozen at accept so upstream may move on.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            ll_x_q   <= '0;
            ur_x_q   <= '0;
            ur_y_q   <= '0;
            stride_q <= '0;
            tri_q    <= '0;
            color_q  <= '0;
        end else begin
            valid_q <= (state_d == TEST_STATE);
            if (accept) begin
                x_q      <= box_R13S[0][0];
                y_q      <= box_R13S[0][1];
                ll_x_q   <= box_R13S[0][0];
                ur_x_q   <= box_R13S[1][0];
                ur_y_q   <= box_R13S[1][1];
                stride_q <= stride_d;
                tri_q    <= tri_R13S;
                color_q  <= color_R13U;
            end else if (state_q == TEST_STATE) begin
                x_q <= next_x;
                y_q <= next_y;
            end
        end
    end

    assign tri_R14S       = tri_q;
    assign color_R14U     = color_q;
    assign sample_R14S[0] = x_q;
    assign sample_R14S[1] = y_q;
    assign validSamp_R14H = valid_q;

endmodule
